// File: rtl/mul256_pkg.sv
// Shared widths, word counts and FSM state type for the
// word-serial 256x256 multiplier front/back end.
package mul256_pkg;

  localparam int WORD_W      = 64;
  localparam int OP_W        = 256;
  localparam int PROD_W      = 2 * OP_W;
  localparam int N_IN_WORDS  = 2 * OP_W / WORD_W;
  localparam int N_OUT_WORDS = 2 * OP_W / WORD_W;
  localparam int IN_CW       = $clog2(N_IN_WORDS);
  localparam int OUT_CW      = $clog2(N_OUT_WORDS);

  typedef enum logic [1:0] {
    LOAD,
    WAIT,
    STREAM
  } state_e;

endpackage

// File: rtl/mul256_word_serializer.sv
// Captures the 512-bit product and returns it as 64-bit
// words LSW first over a valid/ready stream.
module mul256_word_serializer
  import mul256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [PROD_W-1:0] product_i,
  input  logic              m_ready_i,
  output logic              m_valid_o,
  output logic [WORD_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              done_o
);

  logic [PROD_W-1:0] res_q, res_d;
  logic [OUT_CW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [WORD_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              hs, fin;

  assign hs      = vld_q & m_ready_i;
  assign fin     = hs & (cnt_q == OUT_CW'(N_OUT_WORDS - 1));
  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    res_d  = res_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (load_i) begin
      res_d  = product_i;
      data_d = product_i[WORD_W-1:0];
      vld_d  = 1'b1;
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (fin) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end else if (hs) begin
      cnt_d  = cnt_nxt;
      data_d = res_q[cnt_nxt*WORD_W +: WORD_W];
      last_d = (cnt_nxt == OUT_CW'(N_OUT_WORDS - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign m_valid_o = vld_q;
  assign m_data_o  = data_q;
  assign m_last_o  = last_q;
  assign done_o    = fin;

endmodule

// File: rtl/mul256_word_stream.sv
// Word-serial front end: packs operand words, holds them for
// the multiplier latency, then hands the product to the serializer.
module mul256_word_stream
  import mul256_pkg::*;
#(
  parameter int MUL_WAIT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic [OP_W-1:0]   mul_x,
  output logic [OP_W-1:0]   mul_y,
  input  logic [PROD_W-1:0] mul_product,
  output logic              busy
);

  localparam int WCW  = $clog2(MUL_WAIT + 1);
  localparam int HALF = N_IN_WORDS / 2;
  localparam int HCW  = $clog2(HALF);

  state_e           state_q, state_d;
  logic [IN_CW-1:0] in_cnt_q, in_cnt_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             s_ready_q, s_ready_d;
  logic [OP_W-1:0]  x_q, x_d, y_q, y_d;
  logic [HCW-1:0]   widx;
  logic             acc, load, done;

  assign acc  = s_valid & s_ready_q;
  assign widx = in_cnt_q[HCW-1:0];

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    wait_d    = wait_q;
    s_ready_d = s_ready_q;
    x_d       = x_q;
    y_d       = y_q;
    load      = 1'b0;
    unique case (state_q)
      LOAD: begin
        s_ready_d = 1'b1;
        if (acc) begin
          if (!in_cnt_q[IN_CW-1]) x_d[widx*WORD_W +: WORD_W] = s_data;
          else                    y_d[widx*WORD_W +: WORD_W] = s_data;
          if (in_cnt_q == IN_CW'(N_IN_WORDS - 1)) begin
            in_cnt_d  = '0;
            state_d   = WAIT;
            wait_d    = WCW'(MUL_WAIT - 1);
            s_ready_d = 1'b0;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        // sample on the MUL_WAIT-th edge after the last operand word
        if (wait_q == '0) begin
          load    = 1'b1;
          state_d = STREAM;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      STREAM: begin
        if (done) begin
          state_d   = LOAD;
          s_ready_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      in_cnt_q  <= '0;
      wait_q    <= '0;
      s_ready_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      wait_q    <= wait_d;
      s_ready_q <= s_ready_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  mul256_word_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .product_i (mul_product),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .done_o    (done)
  );

  assign s_ready = s_ready_q;
  assign mul_x   = x_q;
  assign mul_y   = y_q;
  assign busy    = (state_q != LOAD);

endmodule

// File: tb/tb_mul256_word_stream.sv
// Scoreboard bench: random operands in, product words out,
// compared against plain-arithmetic products.
module tb_mul256_word_stream;
  import mul256_pkg::*;

  localparam int MW  = 5;
  localparam int TMO = 200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [WORD_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [WORD_W-1:0] m_data;
  logic              m_last;
  logic [OP_W-1:0]   mul_x, mul_y;
  logic [PROD_W-1:0] mul_product;
  logic              busy;

  logic [PROD_W-1:0] p1, p2, p3, p4;

  typedef struct packed {
    logic [WORD_W-1:0] d;
    logic              last;
  } exp_t;

  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
  } op_t;

  exp_t exp_q[$];
  op_t  op_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int in_idx = 0;
  int acc_edge = 0;
  int rel_cnt = 0;
  bit in_flight = 0;
  bit sr_next = 0;
  bit prev_valid = 0;
  bit prev_stall = 0;
  bit rnd_ready = 0;
  logic [WORD_W-1:0] prev_data;
  logic              prev_last;
  logic [OP_W-1:0]   fl_x, fl_y;
  exp_t              e;
  op_t               o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in for karatsuba256: four register stages, never reset
  always @(posedge clk) begin
    p1 <= PROD_W'(mul_x) * PROD_W'(mul_y);
    p2 <= p1;
    p3 <= p2;
    p4 <= p3;
  end
  assign mul_product = p4;

  always @(posedge clk) begin
    #1;
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  mul256_word_stream #(.MUL_WAIT(MW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_product (mul_product),
    .busy        (busy)
  );

  task automatic check(input string nm,
                       input logic [PROD_W-1:0] act,
                       input logic [PROD_W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctrl", PROD_W'({s_ready, m_valid, m_last, busy}), '0);
      check("rst_mdata", PROD_W'(m_data), '0);
      check("rst_mulx", PROD_W'(mul_x), '0);
      check("rst_muly", PROD_W'(mul_y), '0);
      in_idx = 0;
      in_flight = 0;
      sr_next = 0;
      prev_valid = 0;
      prev_stall = 0;
      rel_cnt = 0;
      op_q.delete();
    end else begin
      if (rel_cnt < 3) rel_cnt++;
      if (rel_cnt == 1) check("sready_pre", PROD_W'(s_ready), '0);
      if (rel_cnt == 2) check("sready_rise", PROD_W'(s_ready), 1);
      if (sr_next) begin
        check("sready_after_last", PROD_W'(s_ready), 1);
        sr_next = 0;
      end
      if (in_flight) begin
        check("sready_low", PROD_W'(s_ready), '0);
        check("mulx_hold", PROD_W'(mul_x), PROD_W'(fl_x));
        check("muly_hold", PROD_W'(mul_y), PROD_W'(fl_y));
      end
      if (prev_stall) begin
        check("stall_valid", PROD_W'(m_valid), 1);
        check("stall_data", PROD_W'(m_data), PROD_W'(prev_data));
        check("stall_last", PROD_W'(m_last), PROD_W'(prev_last));
      end
      if (m_valid && !prev_valid)
        check("latency", PROD_W'(cyc - acc_edge), MW);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
        end else begin
          e = exp_q.pop_front();
          check("data", PROD_W'(m_data), PROD_W'(e.d));
          check("last", PROD_W'(m_last), PROD_W'(e.last));
          if (e.last) begin
            in_flight = 0;
            sr_next = 1;
          end
        end
      end
      if (s_valid && s_ready) begin
        if (in_idx == N_IN_WORDS - 1) begin
          in_idx = 0;
          in_flight = 1;
          acc_edge = cyc + 1;
          if (op_q.size() != 0) begin
            o = op_q.pop_front();
            fl_x = o.x;
            fl_y = o.y;
          end
        end else begin
          in_idx++;
        end
      end
      prev_valid = m_valid;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic send_word(input logic [WORD_W-1:0] d, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > TMO) begin
        n_cmp++;
        n_bad++;
        $display("FAIL s_ready_timeout: got 0, expected 1 within %0d cycles", TMO);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic run_op(input logic [OP_W-1:0] x,
                        input logic [OP_W-1:0] y,
                        input logic [PROD_W-1:0] expv,
                        input int maxgap);
    logic [WORD_W-1:0] w;
    exp_t ee;
    op_q.push_back('{x: x, y: y});
    for (int k = 0; k < N_IN_WORDS; k++) begin
      if (k < N_IN_WORDS / 2) w = x[k*WORD_W +: WORD_W];
      else                    w = y[(k - N_IN_WORDS/2)*WORD_W +: WORD_W];
      send_word(w, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    for (int i = 0; i < N_OUT_WORDS; i++) begin
      ee.d = expv[i*WORD_W +: WORD_W];
      ee.last = (i == N_OUT_WORDS - 1);
      exp_q.push_back(ee);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < TMO) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d words left, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OP_W-1:0] rnd_op();
    logic [OP_W-1:0] v;
    for (int j = 0; j < OP_W / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [OP_W-1:0]   x, y;
    logic [PROD_W-1:0] ex2;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(OP_W'(1), OP_W'(1), PROD_W'(1), 0);
    drain();

    ex2 = {{3{64'hFFFF_FFFF_FFFF_FFFF}}, 64'hFFFF_FFFF_FFFF_FFFE,
           {3{64'h0}}, 64'h1};
    run_op('1, '1, ex2, 0);
    drain();

    rnd_ready = 1;
    for (int t = 0; t < 4; t++) begin
      x = rnd_op();
      y = rnd_op();
      run_op(x, y, PROD_W'(x) * PROD_W'(y), 0);
      drain();
    end
    rnd_ready = 0;

    for (int t = 0; t < 4; t++) begin
      x = rnd_op();
      y = rnd_op();
      run_op(x, y, PROD_W'(x) * PROD_W'(y), 3);
      drain();
    end

    x = rnd_op();
    for (int k = 0; k < 5; k++) send_word(x[(k%4)*WORD_W +: WORD_W], 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(OP_W'(3), OP_W'(5), PROD_W'(15), 0);
    drain();

    for (int t = 0; t < 20; t++) begin
      x = rnd_op();
      y = rnd_op();
      run_op(x, y, PROD_W'(x) * PROD_W'(y), 0);
    end
    drain();

    repeat (5) @(posedge clk);
    check("queue_empty", PROD_W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
